// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode, register ID, status and condition-code definitions
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_INS = 2'd2
    } stat_t;

    localparam int CC_OF = 2;
    localparam int CC_SF = 1;
    localparam int CC_ZF = 0;

    localparam logic [2:0] CC_RESET = 3'b001;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 15-entry register file, two write ports (M wins), combinational reads; debug read port under REGFILE_DBG_EN
module regfile #(
    parameter int NREG = 15,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      dst_e,
    input  logic [XLEN-1:0] val_e,
    input  logic [3:0]      dst_m,
    input  logic [XLEN-1:0] val_m,
    input  logic [3:0]      src_a,
    input  logic [3:0]      src_b,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b
`ifdef REGFILE_DBG_EN
    ,
    input  logic [3:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_val
`endif
);

    localparam logic [3:0] NREG_ID = 4'(NREG);

    logic [XLEN-1:0] regs [NREG];

    // Port M is written last so it overrides port E when both target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            if (dst_e < NREG_ID) regs[dst_e] <= val_e;
            if (dst_m < NREG_ID) regs[dst_m] <= val_m;
        end
    end

    assign rd_a = (src_a < NREG_ID) ? regs[src_a] : '0;
    assign rd_b = (src_b < NREG_ID) ? regs[src_b] : '0;

`ifdef REGFILE_DBG_EN
    assign dbg_val = (dbg_sel < NREG_ID) ? regs[dbg_sel] : '0;
`endif

endmodule

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode/write-back: operand select, CC, status FSM, retire counter; REGFILE_DBG_EN adds debug read port
module decode_writeback
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      icode,
    input  logic [3:0]      rA,
    input  logic [3:0]      rB,
    input  logic [XLEN-1:0] valE_in,
    input  logic [XLEN-1:0] valM_in,
    input  logic            cnd_in,
    input  logic [2:0]      cc_in,
    input  logic            wb_en,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    output logic [2:0]      cc_out,
    output logic [1:0]      stat,
    output logic [63:0]     instr_count
`ifdef REGFILE_DBG_EN
    ,
    input  logic [3:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_val
`endif
);

    logic [3:0] src_a, src_b, dst_e, dst_m;
    stat_t      stat_q, stat_d;
    logic [2:0] cc_q;
    logic [63:0] count_q;
    logic       commit;

    assign commit = wb_en && (stat_q == STAT_AOK);

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_RRMOVQ: begin src_a = rA; dst_e = cnd_in ? rB : RNONE; end
            I_IRMOVQ: dst_e = rB;
            I_RMMOVQ: begin src_a = rA; src_b = rB; end
            I_MRMOVQ: begin src_b = rB; dst_m = rA; end
            I_OPQ:    begin src_a = rA; src_b = rB; dst_e = rB; end
            I_CALL:   begin src_b = RSP; dst_e = RSP; end
            I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            I_PUSHQ:  begin src_a = rA; src_b = RSP; dst_e = RSP; end
            I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = rA; end
            default: ;
        endcase
    end

    regfile #(.NREG(NREG), .XLEN(XLEN)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (commit),
        .dst_e   (dst_e),
        .val_e   (valE_in),
        .dst_m   (dst_m),
        .val_m   (valM_in),
        .src_a   (src_a),
        .src_b   (src_b),
        .rd_a    (valA),
        .rd_b    (valB)
`ifdef REGFILE_DBG_EN
        ,
        .dbg_sel (dbg_sel),
        .dbg_val (dbg_val)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= STAT_AOK;
        else        stat_q <= stat_d;
    end

    // HLT and INS are absorbing; only a reset returns to AOK.
    always_comb begin
        stat_d = stat_q;
        if (commit) begin
            if (icode == I_HALT)     stat_d = STAT_HLT;
            else if (icode > I_POPQ) stat_d = STAT_INS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q    <= CC_RESET;
            count_q <= '0;
        end else if (commit) begin
            count_q <= count_q + 64'd1;
            if (icode == I_OPQ) cc_q <= cc_in;
        end
    end

    assign cc_out      = cc_q;
    assign stat        = stat_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - directed self-checking bench for decode_writeback
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic [63:0] valE_in, valM_in;
    logic        cnd_in;
    logic [2:0]  cc_in;
    logic        wb_en;
    logic [63:0] valA, valB;
    logic [2:0]  cc_out;
    logic [1:0]  stat;
    logic [63:0] instr_count;
`ifdef REGFILE_DBG_EN
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    decode_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .valE_in     (valE_in),
        .valM_in     (valM_in),
        .cnd_in      (cnd_in),
        .cc_in       (cc_in),
        .wb_en       (wb_en),
        .valA        (valA),
        .valB        (valB),
        .cc_out      (cc_out),
        .stat        (stat),
        .instr_count (instr_count)
`ifdef REGFILE_DBG_EN
        ,
        .dbg_sel     (dbg_sel),
        .dbg_val     (dbg_val)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [63:0] ve, input logic [63:0] vm,
                          input logic cnd, input logic [2:0] cc);
        @(negedge clk);
        icode = ic; rA = ra; rB = rb; valE_in = ve; valM_in = vm; cnd_in = cnd; cc_in = cc;
        wb_en = 1'b1;
        @(posedge clk);
        #1 wb_en = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] id, output logic [63:0] v);
        icode = 4'h6; rA = id; rB = 4'hF;
        #1 v = valA;
    endtask

    logic [63:0] r;

    initial begin
        rst_n = 1'b0; wb_en = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
        valE_in = '0; valM_in = '0; cnd_in = 1'b0; cc_in = 3'b000;
`ifdef REGFILE_DBG_EN
        dbg_sel = 4'hF;
`endif
        #12;
        check_eq("reset_stat", {62'd0, stat}, 64'd0);
        check_eq("reset_cc", {61'd0, cc_out}, 64'd1);
        check_eq("reset_count", instr_count, 64'd0);
        read_reg(4'd2, r); check_eq("reset_r2", r, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // irmovq $0x1234, %rdx
        commit(4'h3, 4'hF, 4'd2, 64'h1234, 64'h0, 1'b0, 3'b000);
        read_reg(4'd2, r); check_eq("irmovq_r2", r, 64'h1234);
        check_eq("irmovq_count", instr_count, 64'd1);
        icode = 4'h4; rA = 4'hF; rB = 4'd2; #1;
        check_eq("rmmovq_valB", valB, 64'h1234);

        // opq loads CC, irmovq leaves it
        commit(4'h6, 4'd2, 4'd3, 64'h55, 64'h0, 1'b0, 3'b010);
        check_eq("opq_cc", {61'd0, cc_out}, 64'd2);
        read_reg(4'd3, r); check_eq("opq_r3", r, 64'h55);
        commit(4'h3, 4'hF, 4'd6, 64'h9, 64'h0, 1'b0, 3'b101);
        check_eq("irmovq_cc_kept", {61'd0, cc_out}, 64'd2);

        // cmovq not taken, then taken
        commit(4'h2, 4'd2, 4'd5, 64'h7, 64'h0, 1'b0, 3'b000);
        read_reg(4'd5, r); check_eq("cmov_nt_r5", r, 64'h0);
        commit(4'h2, 4'd2, 4'd5, 64'h7, 64'h0, 1'b1, 3'b000);
        read_reg(4'd5, r); check_eq("cmov_t_r5", r, 64'h7);
        check_eq("cmov_count", instr_count, 64'd5);

        // popq %rsp: M port wins; operands show pre-commit %rsp
        commit(4'h3, 4'hF, 4'd4, 64'h100, 64'h0, 1'b0, 3'b000);
        @(negedge clk);
        icode = 4'hB; rA = 4'd4; rB = 4'hF; valE_in = 64'h108; valM_in = 64'hABC;
        wb_en = 1'b1; #1;
        check_eq("popq_valA_pre", valA, 64'h100);
        check_eq("popq_valB_pre", valB, 64'h100);
        @(posedge clk); #1 wb_en = 1'b0;
        read_reg(4'd4, r); check_eq("popq_r4", r, 64'hABC);

        // pushq decode: valA=rA, valB=%rsp
        icode = 4'hA; rA = 4'd5; rB = 4'hF; #1;
        check_eq("pushq_valA", valA, 64'h7);
        check_eq("pushq_valB", valB, 64'hABC);

        // write to F dropped, F reads zero
        commit(4'h3, 4'hF, 4'hF, 64'hDEAD, 64'h0, 1'b0, 3'b000);
        read_reg(4'd14, r); check_eq("rnone_r14", r, 64'h0);
        read_reg(4'hF, r); check_eq("rnone_read", r, 64'h0);
        check_eq("pre_halt_count", instr_count, 64'd8);

        // halt: counted once, then everything frozen
        commit(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 3'b000);
        check_eq("halt_stat", {62'd0, stat}, 64'd1);
        check_eq("halt_count", instr_count, 64'd9);
        commit(4'h3, 4'hF, 4'd2, 64'hFFFF, 64'h0, 1'b0, 3'b000);
        commit(4'h6, 4'd2, 4'd3, 64'h77, 64'h0, 1'b0, 3'b111);
        read_reg(4'd2, r); check_eq("halt_r2_frozen", r, 64'h1234);
        read_reg(4'd3, r); check_eq("halt_r3_frozen", r, 64'h55);
        check_eq("halt_cc_frozen", {61'd0, cc_out}, 64'd2);
        check_eq("halt_count_frozen", instr_count, 64'd9);
        check_eq("halt_absorbing", {62'd0, stat}, 64'd1);

        // asynchronous reset mid-stream with wb_en high
        @(negedge clk);
        icode = 4'h3; rB = 4'd2; valE_in = 64'h99; wb_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_stat", {62'd0, stat}, 64'd0);
        check_eq("rst_cc", {61'd0, cc_out}, 64'd1);
        check_eq("rst_count", instr_count, 64'd0);
        wb_en = 1'b0;
        read_reg(4'd2, r); check_eq("rst_r2", r, 64'h0);
        read_reg(4'd4, r); check_eq("rst_r4", r, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // invalid icode: INS, no writes, counted
        commit(4'hC, 4'd2, 4'd2, 64'h5, 64'h6, 1'b1, 3'b111);
        check_eq("ins_stat", {62'd0, stat}, 64'd2);
        check_eq("ins_count", instr_count, 64'd1);
        check_eq("ins_cc", {61'd0, cc_out}, 64'd1);
        read_reg(4'd2, r); check_eq("ins_r2", r, 64'h0);
        commit(4'h3, 4'hF, 4'd2, 64'h42, 64'h0, 1'b0, 3'b000);
        read_reg(4'd2, r); check_eq("ins_r2_frozen", r, 64'h0);
        check_eq("ins_count_frozen", instr_count, 64'd1);
`ifdef REGFILE_DBG_EN
        dbg_sel = 4'hF; #1;
        check_eq("dbg_rnone", dbg_val, 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Decode/write-back stage of the sequential Y86-64 core, closing the loop around the execute stage. It selects source and destination registers from icode/rA/rB and drives valA/valB into execute from a 15×64-bit register file. It commits valE/valM on a write-back strobe. It also holds the OF/SF/ZF condition-code register that feeds execute, plus sticky processor status and a retired-instruction counter.

## Interface
Parameters:
- NREG, 15, architectural registers (IDs 0..14; 4'hF = none)
- XLEN, 64, data width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- icode  in  4  instruction code of current instruction
- rA, rB  in  4  register specifiers
- valE_in  in  64  execute result
- valM_in  in  64  memory read data
- cnd_in  in  1  condition result from execute
- cc_in  in  3  {OF,SF,ZF} flags computed by execute
- wb_en  in  1  commit strobe, one pulse per instruction
- valA, valB  out  64  register operands to execute
- cc_out  out  3  {OF,SF,ZF} stored flags to execute
- stat  out  2  0 AOK, 1 HLT, 2 INS
- instr_count  out  64  retired instructions

## Operation
- srcA: icode 2,4,6,A → rA; 9,B → 4 (%rsp); otherwise F.
- srcB: icode 4,5,6 → rB; 8,9,A,B → 4; otherwise F.
- dstE: icode 2 → rB if cnd_in, else F; icode 3,6 → rB; icode 8,9,A,B → 4; otherwise F.
- dstM: icode 5,B → rA; otherwise F.
- Reads are combinational.
  - Register ID F reads 0.
  - valA/valB show pre-commit contents. There is no same-cycle bypass, which keeps the execute path free of combinational loops.
- On a rising edge with wb_en=1 and stat=AOK:
  - Write valE_in to dstE.
  - Write valM_in to dstM.
  - Writes to F are dropped.
  - If dstE==dstM (popq %rsp), valM_in wins.
- CC register loads cc_in only when wb_en=1, icode=6 and stat=AOK.
- Status state machine:
  - AOK → HLT on a committed icode 0.
  - AOK → INS on a committed icode > B.
  - HLT and INS are absorbing until reset.
  - In HLT/INS, register, CC and counter writes are suppressed.
- instr_count increments on every wb_en commit made in AOK, including the halting instruction. It wraps modulo 2^64.

## Timing
- Reset values: all registers 0, cc_out=3'b001 (ZF=1), stat=0 (AOK), instr_count=0.
- Reset asserted mid-operation clears state immediately, regardless of wb_en.
- Write latency is 1 cycle: a value committed at edge N is visible on valA/valB after edge N.
- wb_en held high for several cycles commits on each edge; a single-cycle pulse is expected from control.
- valA/valB/srcX/dstX depend only on current inputs and stored state (no input registering).

## Configuration
- REGFILE_DBG_EN defined:
  - adds input dbg_sel[3:0] and output dbg_val[63:0], a third combinational read port (F reads 0) for bench/debug register dumps.
- REGFILE_DBG_EN undefined: ports absent, and the register file has exactly two read ports.

## Structure
- Package y86_pkg holds:
  - icode constants (HALT..POPQ)
  - RNONE=4'hF, RSP=4'h4
  - stat encodings
  - CC bit indices (OF=2, SF=1, ZF=0)
- Sub-module regfile:
  - 15×64 storage, 2 write ports with port-M priority, 2 combinational read ports (3 under REGFILE_DBG_EN), async active-low clear.
- Decode selection, CC register, status FSM and counter live in decode_writeback.

## Test plan
- irmovq: icode=3, rB=2, valE_in=0x1234, wb_en pulse → next cycle, icode=6 rA=2 gives valA=0x1234; instr_count=1.
- opq CC: icode=6, cc_in=3'b010, wb_en → cc_out=3'b010; a following icode=3 commit with cc_in=3'b101 leaves cc_out=3'b010.
- cmovq not taken: icode=2, cnd_in=0, rB=5, valE_in=7 → R5 unchanged. Same instruction with cnd_in=1 → R5=7.
- popq %rsp: R4=0x100, icode=B, rA=4, valE_in=0x108, valM_in=0xABC → R4=0xABC; valA=valB=0x100 before the edge.
- halt: icode=0 commit → stat=1, instr_count increments once. Subsequent icode=3 commits change no register and no count. rst_n low mid-stream → stat=0, cc_out=001, all regs 0.
- Invalid: icode=C commit → stat=2, no writes; under REGFILE_DBG_EN, dbg_sel=F → dbg_val=0.
